// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Write-back scheduler and hazard scoreboard for the 32-entry
//               RV32I register file. The ALU and LSU share the single write
//               port through valid/ready handshakes with round-robin
//               arbitration. A busy bit per register stalls dependent issues
//               (RAW and WAW) until the write of that register completes.
// Ports       : clk, rst_n            - clock, async active-low reset
//               issue_*               - decode/issue request, issue_stall out
//               alu_wb_*, lsu_wb_*    - write-back requesters (valid/ready)
//               rf_reg_write/rd/data  - registered register-file write port
//               busy_count            - number of busy scoreboard bits
//               wb_err                - sticky write-back to non-busy register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            issue_valid,
  input  logic            issue_uses_rd,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            issue_stall,

  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,

  input  logic            lsu_wb_valid,
  input  logic [4:0]      lsu_wb_rd,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_ready,

  output logic            rf_reg_write,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  output logic [5:0]      busy_count,
  output logic            wb_err
);

  // Round-robin pointer encoding: which requester won the last transfer.
  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_LSU = 1'b1;

  logic [31:0]     busy_q, busy_d;
  logic [5:0]      busy_count_q, busy_count_d;
  logic            rf_reg_write_q, rf_reg_write_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_write_data_q, rf_write_data_d;
  logic            wb_err_q, wb_err_d;
  logic            last_q, last_d;

  logic            grant_alu;
  logic            grant_lsu;
  logic            accept;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;
  logic            issue_fire;

  // --------------------------------------------------------------------------
  // Hazard detection. busy_q[0] is always 0, so x0 never causes a stall.
  // --------------------------------------------------------------------------
  assign issue_stall = issue_valid &
                       (busy_q[issue_rs1] | busy_q[issue_rs2] |
                        (issue_uses_rd & busy_q[issue_rd]));
  assign issue_fire  = issue_valid & ~issue_stall;

  // --------------------------------------------------------------------------
  // Round-robin arbitration: on a tie, the requester not granted last wins.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (alu_wb_valid && lsu_wb_valid) begin
      if (last_q == LAST_ALU) begin
        grant_lsu = 1'b1;
      end else begin
        grant_alu = 1'b1;
      end
    end else if (alu_wb_valid) begin
      grant_alu = 1'b1;
    end else if (lsu_wb_valid) begin
      grant_lsu = 1'b1;
    end
  end

  // Readies are held low while reset is asserted so nothing appears accepted.
  assign alu_wb_ready = grant_alu & rst_n;
  assign lsu_wb_ready = grant_lsu & rst_n;

  assign accept   = grant_alu | grant_lsu;
  assign acc_rd   = grant_lsu ? lsu_wb_rd   : alu_wb_rd;
  assign acc_data = grant_lsu ? lsu_wb_data : alu_wb_data;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    // The cycle holding rf_reg_write=1 ends with the register file write,
    // so the destination becomes available at this edge.
    if (rf_reg_write_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    // WAW stalling guarantees this index differs from the one cleared above.
    if (issue_fire && issue_uses_rd && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    busy_count_d = 6'd0;
    for (int i = 0; i < 32; i++) begin
      busy_count_d = busy_count_d + {5'd0, busy_d[i]};
    end

    rf_reg_write_d  = accept && (acc_rd != 5'd0);
    rf_rd_d         = accept ? acc_rd   : rf_rd_q;
    rf_write_data_d = accept ? acc_data : rf_write_data_q;

    // Judged against the busy state before this edge's updates.
    wb_err_d = wb_err_q | (accept && (acc_rd != 5'd0) && !busy_q[acc_rd]);

    last_d = last_q;
    if (grant_lsu) begin
      last_d = LAST_LSU;
    end else if (grant_alu) begin
      last_d = LAST_ALU;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q          <= 32'd0;
      busy_count_q    <= 6'd0;
      rf_reg_write_q  <= 1'b0;
      rf_rd_q         <= 5'd0;
      rf_write_data_q <= '0;
      wb_err_q        <= 1'b0;
      last_q          <= LAST_ALU;
    end else begin
      busy_q          <= busy_d;
      busy_count_q    <= busy_count_d;
      rf_reg_write_q  <= rf_reg_write_d;
      rf_rd_q         <= rf_rd_d;
      rf_write_data_q <= rf_write_data_d;
      wb_err_q        <= wb_err_d;
      last_q          <= last_d;
    end
  end

  assign rf_reg_write  = rf_reg_write_q;
  assign rf_rd         = rf_rd_q;
  assign rf_write_data = rf_write_data_q;
  assign busy_count    = busy_count_q;
  assign wb_err        = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Self-checking bench for regfile_wb_scheduler. A behavioural
//               model (busy set, round-robin winner, pending write) predicts
//               every output each cycle; directed scenarios add literal
//               expectations; a randomized phase exercises contention.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_valid = 1'b0;
  logic            issue_uses_rd = 1'b0;
  logic [4:0]      issue_rd = 5'd0;
  logic [4:0]      issue_rs1 = 5'd0;
  logic [4:0]      issue_rs2 = 5'd0;
  logic            issue_stall;
  logic            alu_wb_valid = 1'b0;
  logic [4:0]      alu_wb_rd = 5'd0;
  logic [XLEN-1:0] alu_wb_data = '0;
  logic            alu_wb_ready;
  logic            lsu_wb_valid = 1'b0;
  logic [4:0]      lsu_wb_rd = 5'd0;
  logic [XLEN-1:0] lsu_wb_data = '0;
  logic            lsu_wb_ready;
  logic            rf_reg_write;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_write_data;
  logic [5:0]      busy_count;
  logic            wb_err;

  regfile_wb_scheduler #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_uses_rd(issue_uses_rd),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_stall  (issue_stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .rf_reg_write (rf_reg_write),
    .rf_rd        (rf_rd),
    .rf_write_data(rf_write_data),
    .busy_count   (busy_count),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [31:0]     m_busy     = 32'd0;  // set of registers awaiting a write
  logic            m_lsu_last = 1'b0;   // 1: LSU won the most recent transfer
  logic            m_we       = 1'b0;
  logic [4:0]      m_rd       = 5'd0;
  logic [XLEN-1:0] m_data     = '0;
  logic            m_err      = 1'b0;
  logic            m_acc_alu  = 1'b0;   // accepted at the most recent edge
  logic            m_acc_lsu  = 1'b0;

  function automatic logic model_stall();
    return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                           (issue_uses_rd && m_busy[issue_rd]));
  endfunction

  // Returns {lsu_wins, alu_wins}.
  function automatic logic [1:0] model_grant();
    if (alu_wb_valid && lsu_wb_valid) return m_lsu_last ? 2'b01 : 2'b10;
    return {lsu_wb_valid, alu_wb_valid};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 32'd0; m_lsu_last = 1'b0; m_we = 1'b0; m_rd = 5'd0;
        m_data = '0; m_err = 1'b0; m_acc_alu = 1'b0; m_acc_lsu = 1'b0;
      end else begin
        logic [1:0] g;
        logic       fire;
        logic [4:0] wrd;
        g    = model_grant();
        fire = issue_valid && !model_stall();
        wrd  = g[1] ? lsu_wb_rd : alu_wb_rd;
        if (g != 2'b00 && wrd != 5'd0 && !m_busy[wrd]) m_err = 1'b1;
        if (m_we) m_busy[m_rd] = 1'b0;
        if (fire && issue_uses_rd && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        m_acc_alu = g[0];
        m_acc_lsu = g[1];
        if (g != 2'b00) begin
          m_lsu_last = g[1];
          m_rd       = wrd;
          m_data     = g[1] ? lsu_wb_data : alu_wb_data;
          m_we       = (wrd != 5'd0);
        end else begin
          m_we = 1'b0;
        end
      end
    end
  end

  // Compare process: all outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [1:0] g;
      g = model_grant();
      check("issue_stall",   {31'd0, issue_stall},  {31'd0, model_stall()});
      check("alu_wb_ready",  {31'd0, alu_wb_ready}, {31'd0, g[0]});
      check("lsu_wb_ready",  {31'd0, lsu_wb_ready}, {31'd0, g[1]});
      check("ready_onehot",  {31'd0, alu_wb_ready & lsu_wb_ready}, 32'd0);
      check("rf_reg_write",  {31'd0, rf_reg_write}, {31'd0, m_we});
      check("rf_rd",         {27'd0, rf_rd},        {27'd0, m_rd});
      check("rf_write_data", rf_write_data,         m_data);
      check("busy_count",    {26'd0, busy_count},   $countones(m_busy));
      check("wb_err",        {31'd0, wb_err},       {31'd0, m_err});
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_uses_rd = 1'b0;
    issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
  endtask

  task automatic do_reset();
    step();
    #2;
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;

    // ---- Reset mid-transfer ----
    issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rd = 5'd6;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd2; alu_wb_data = 32'h0000_1234;
    step();
    issue_valid = 1'b0;
    alu_wb_data = 32'h0000_5678;
    check("pre_rst_rf_reg_write", {31'd0, rf_reg_write}, 32'd1);
    check("pre_rst_busy_count",   {26'd0, busy_count},   32'd1);
    check("pre_rst_wb_err",       {31'd0, wb_err},       32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rf_reg_write",  {31'd0, rf_reg_write}, 32'd0);
    check("rst_rf_rd",         {27'd0, rf_rd},        32'd0);
    check("rst_rf_write_data", rf_write_data,         32'd0);
    check("rst_busy_count",    {26'd0, busy_count},   32'd0);
    check("rst_wb_err",        {31'd0, wb_err},       32'd0);
    check("rst_alu_ready",     {31'd0, alu_wb_ready}, 32'd0);
    check("rst_lsu_ready",     {31'd0, lsu_wb_ready}, 32'd0);
    check("rst_issue_stall",   {31'd0, issue_stall},  32'd0);
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;

    // ---- Issue rd=5, ALU write-back 0xDEADBEEF, dependent stall timing ----
    issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rd = 5'd5;
    step();
    issue_valid = 1'b0;
    check("rd5_busy_count", {26'd0, busy_count}, 32'd1);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEAD_BEEF;
    #1;
    check("rd5_alu_ready", {31'd0, alu_wb_ready}, 32'd1);
    step();                                   // edge N
    alu_wb_valid = 1'b0;
    issue_valid = 1'b1; issue_uses_rd = 1'b0; issue_rd = 5'd0;
    issue_rs1 = 5'd5; issue_rs2 = 5'd0;
    #1;
    check("n1_rf_reg_write", {31'd0, rf_reg_write}, 32'd1);
    check("n1_rf_rd",        {27'd0, rf_rd},        32'd5);
    check("n1_rf_data",      rf_write_data,         32'hDEAD_BEEF);
    check("n1_stall_rs1",    {31'd0, issue_stall},  32'd1);
    step();                                   // edge N+1
    check("n2_stall_rs1",    {31'd0, issue_stall},  32'd0);
    check("n2_busy_count",   {26'd0, busy_count},   32'd0);
    clear_inputs();

    // ---- rd=0 is never busy and never written ----
    issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rd = 5'd0;
    step();
    issue_valid = 1'b0;
    check("x0_busy_count", {26'd0, busy_count}, 32'd0);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h0000_00AA;
    step();
    alu_wb_valid = 1'b0;
    check("x0_rf_reg_write", {31'd0, rf_reg_write}, 32'd0);
    check("x0_wb_err",       {31'd0, wb_err},       32'd0);

    // ---- WAW and rs2 hazards on register 7 ----
    issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rd = 5'd7;
    step();
    #1;
    check("waw_stall", {31'd0, issue_stall}, 32'd1);
    issue_uses_rd = 1'b0; issue_rd = 5'd0; issue_rs2 = 5'd7;
    #1;
    check("rs2_stall", {31'd0, issue_stall}, 32'd1);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h0000_0777;
    step();                                   // accept edge
    alu_wb_valid = 1'b0;
    check("r7_stall_n1", {31'd0, issue_stall}, 32'd1);
    step();                                   // clear edge
    check("r7_stall_n2", {31'd0, issue_stall}, 32'd0);
    clear_inputs();

    // ---- Continuous contention: LSU first, then strict alternation ----
    do_reset();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h0000_0A03;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd4; lsu_wb_data = 32'h0000_0B04;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("rr_lsu_ready", {31'd0, lsu_wb_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_alu_ready", {31'd0, alu_wb_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
    end
    clear_inputs();

    // ---- Write-back to a non-busy register: sticky wb_err ----
    do_reset();
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd9; lsu_wb_data = 32'h0000_0999;
    step();
    lsu_wb_valid = 1'b0;
    check("r9_rf_reg_write", {31'd0, rf_reg_write}, 32'd1);
    check("r9_rf_rd",        {27'd0, rf_rd},        32'd9);
    check("r9_wb_err",       {31'd0, wb_err},       32'd1);
    repeat (5) step();
    check("r9_wb_err_sticky", {31'd0, wb_err}, 32'd1);

    // ---- Randomized traffic against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
      end
      if (!alu_wb_valid || m_acc_alu) begin
        alu_wb_valid = ($urandom_range(99) < 60);
        alu_wb_rd    = 5'($urandom_range(7));
        alu_wb_data  = $urandom;
      end
      if (!lsu_wb_valid || m_acc_lsu) begin
        lsu_wb_valid = ($urandom_range(99) < 50);
        lsu_wb_rd    = 5'($urandom_range(7));
        lsu_wb_data  = $urandom;
      end
      issue_valid   = ($urandom_range(1) == 1);
      issue_uses_rd = ($urandom_range(3) != 0);
      issue_rd      = 5'($urandom_range(7));
      issue_rs1     = 5'($urandom_range(7));
      issue_rs2     = 5'($urandom_range(7));
      step();
    end
    clear_inputs();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and hazard scoreboard for the 32-entry RV32I register file. Shares the register file's single write port between the ALU and load/store unit through valid/ready handshakes with round-robin arbitration, drives the port through registered outputs, and tracks in-flight destination registers so that dependent instructions stall at issue. It sits between decode/issue, the two execution units and the register file.

## Interface
- XLEN, 32, data width of the write port.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- issue_valid  in  1  decode presents an instruction for issue.
- issue_uses_rd  in  1  instruction writes a destination register.
- issue_rd  in  5  destination register index.
- issue_rs1, issue_rs2  in  5 each  source register indices.
- issue_stall  out  1  instruction must not issue this cycle.
- alu_wb_valid  in  1  ALU result pending.
- alu_wb_rd  in  5  ALU destination index.
- alu_wb_data  in  XLEN  ALU result.
- alu_wb_ready  out  1  ALU result accepted this cycle.
- lsu_wb_valid  in  1  load data pending.
- lsu_wb_rd  in  5  load destination index.
- lsu_wb_data  in  XLEN  load data.
- lsu_wb_ready  out  1  load data accepted this cycle.
- rf_reg_write  out  1  register file write enable (registered).
- rf_rd  out  5  register file write index (registered).
- rf_write_data  out  XLEN  register file write data (registered).
- busy_count  out  6  number of scoreboard bits set (0..31).
- wb_err  out  1  sticky: write-back accepted for a register not marked busy.

## Operation
- Scoreboard: 32-bit busy vector; bit 0 hard-wired 0.
- issue_stall = issue_valid & (busy[rs1] | busy[rs2] | (issue_uses_rd & busy[rd])); combinational. Covers RAW and WAW.
- Issue fires on issue_valid & !issue_stall; if issue_uses_rd and issue_rd != 0, set busy[issue_rd] at that edge.
- Arbitration, combinational: one valid requester gets ready; both valid -> grant the one not granted last (round-robin pointer `last`, updated only on an accepted transfer). Reset value of `last` = ALU, so LSU wins the first tie.
- At most one ready high per cycle; no ready when neither valid. Requesters hold valid/rd/data stable until ready.
- Accepted transfer (valid & ready) at edge N: rf_rd/rf_write_data load the winner's values; rf_reg_write loads (rd != 0). Otherwise rf_reg_write loads 0; rf_rd/rf_write_data hold.
- Busy clear: at the edge that ends a cycle with rf_reg_write=1 (the register file write edge), clear busy[rf_rd].
- Same-edge set and clear of different indices both take effect. Same index cannot occur (WAW stall).
- wb_err set at an accepting edge if rd != 0 and busy[rd]=0; cleared only by reset. The write is still performed.
- busy_count = popcount of busy vector, registered alongside it.

## Timing
- Reset (async assert, any cycle, including mid-transfer): busy=0, busy_count=0, rf_reg_write=0, rf_rd=0, rf_write_data=0, wb_err=0, last=ALU. Pending requests are discarded; requesters re-present after reset. Ready outputs follow combinationally from valids once rst_n is high.
- Write-back latency: accept at edge N -> rf_reg_write=1 during cycle N+1 -> register file updated and busy cleared at edge N+1 -> dependent issue_stall low from cycle N+2.
- Throughput: one write-back per cycle, back-to-back accepts allowed; under continuous contention, grants strictly alternate.
- Scoreboard full (31 bits busy): no special case; further issues with uses_rd stall only via their own hazards.

## Test plan
- Reset: drive rst_n=0 mid-transfer with alu_wb_valid=1 -> all outputs 0 immediately, busy_count=0, wb_err=0.
- Issue rd=5, then ALU write-back rd=5 data 0xDEADBEEF accepted at edge N -> rf_reg_write=1, rf_rd=5, rf_write_data=0xDEADBEEF in cycle N+1; issue of rs1=5 stalls through cycle N+1, issue_stall=0 in N+2.
- Both requesters valid continuously with rd=3/4 -> first grant LSU, then ALU, LSU, ALU alternating; exactly one ready per cycle.
- Issue rd=0 with issue_uses_rd=1 -> busy_count stays 0; write-back rd=0 accepted with rf_reg_write=0, wb_err stays 0.
- Issue rd=7 while busy[7]=1 (WAW) -> issue_stall=1 until the busy[7] clear edge; rs2=7 with busy[7]=1 also stalls.
- LSU write-back rd=9 with busy[9]=0 -> write performed (rf_reg_write=1, rf_rd=9), wb_err=1 and remains 1 until reset.
